// File: rtl/fifo_mem_pkg.sv
// fifo_mem_pkg: shared sizing constants and pointer type for the fifo_mem slice.
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  log2 of FIFO depth
//   DEPTH       number of entries
//   THRESHOLD   occupancy at or above which the half-full flag asserts
//   ptr_t       read/write pointer, one extra MSB used as the wrap bit
package fifo_mem_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    localparam int unsigned THRESHOLD  = 8;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    // Occupancy is the modulo-2^(ADDR_WIDTH+1) pointer difference.
    function automatic ptr_t occupancy(input ptr_t wptr, input ptr_t rptr);
        return wptr - rptr;
    endfunction

endpackage

// File: rtl/fifo_mem_ram.sv
// fifo_mem_ram: storage array for fifo_mem, one synchronous write port and one
// asynchronous read port. The array is not reset.
//   clk_i    clock
//   we_i     write enable, sampled on the rising edge
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i
module fifo_mem_ram
    import fifo_mem_pkg::*;
#(
    parameter int unsigned DataWidth = DATA_WIDTH,
    parameter int unsigned AddrWidth = ADDR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [DataWidth-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_mem.sv
// fifo_mem: single-clock 16 x 8 FIFO with full, empty, threshold and sticky
// overflow/underflow flags. The head word is presented combinationally.
//   clk             clock, rising edge
//   rst_n           synchronous active-low reset (overrides wr/rd)
//   wr / rd         write / read requests
//   data_in         write data
//   data_out        head-of-FIFO word (undefined while empty)
//   fifo_full       occupancy == depth
//   fifo_empty      occupancy == 0
//   fifo_threshold  occupancy >= THRESHOLD
//   fifo_overflow   sticky: write attempted while full (cleared by accepted read)
//   fifo_underflow  sticky: read attempted while empty (cleared by accepted write)
// Build option: define FIFO_ERR_FLAGS_EN to implement the sticky error flags;
// otherwise fifo_overflow and fifo_underflow are tied low.
module fifo_mem
    import fifo_mem_pkg::*;
#(
    parameter int unsigned DataWidth = fifo_mem_pkg::DATA_WIDTH,
    parameter int unsigned AddrWidth = fifo_mem_pkg::ADDR_WIDTH,
    parameter int unsigned Threshold = fifo_mem_pkg::THRESHOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [DataWidth-1:0] data_in,
    output logic [DataWidth-1:0] data_out,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 fifo_threshold,
    output logic                 fifo_overflow,
    output logic                 fifo_underflow
);

    localparam logic [AddrWidth:0] PtrOne = (AddrWidth + 1)'(1);
    localparam logic [AddrWidth:0] ThrVal = (AddrWidth + 1)'(Threshold);

    logic [AddrWidth:0] wptr_q, wptr_d;
    logic [AddrWidth:0] rptr_q, rptr_d;
    logic [AddrWidth:0] occ;
    logic               wr_acc, rd_acc;

    assign occ            = wptr_q - rptr_q;
    assign fifo_empty     = (wptr_q == rptr_q);
    assign fifo_full      = (wptr_q[AddrWidth] != rptr_q[AddrWidth]) &&
                            (wptr_q[AddrWidth-1:0] == rptr_q[AddrWidth-1:0]);
    assign fifo_threshold = (occ >= ThrVal);

    assign wr_acc = wr & ~fifo_full;
    assign rd_acc = rd & ~fifo_empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Reset wins over a concurrent write, so gate the RAM write enable too.
    fifo_mem_ram #(
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc & rst_n),
        .waddr_i (wptr_q[AddrWidth-1:0]),
        .wdata_i (data_in),
        .raddr_i (rptr_q[AddrWidth-1:0]),
        .rdata_o (data_out)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Set and clear conditions are mutually exclusive by construction.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (wr & fifo_full & ~rd) begin
            ovf_d = 1'b1;
        end
        if (rd_acc) begin
            ovf_d = 1'b0;
        end
        if (rd & fifo_empty & ~wr) begin
            unf_d = 1'b1;
        end
        if (wr_acc) begin
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = unf_q;
`else
    assign fifo_overflow  = 1'b0;
    assign fifo_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_mem.sv
// tb_fifo_mem: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based model of the FIFO.
module tb_fifo_mem;

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit Err = 1'b1;
`else
    localparam bit Err = 1'b0;
`endif
    localparam int Depth = 16;
    localparam int Thr   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow;

    int checks = 0;
    int errors = 0;

    fifo_mem dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr             (wr),
        .rd             (rd),
        .data_in        (data_in),
        .data_out       (data_out),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: contents as a queue plus the two sticky bits.
    logic [7:0] q[$];
    bit         m_ovf, m_unf;

    task automatic model_edge(input logic r_n, input logic w, input logic r,
                              input logic [7:0] d);
        int sz;
        sz = q.size();
        if (!r_n) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (Err && w && !r && sz == Depth) m_ovf = 1;
            if (Err && r && !w && sz == 0) m_unf = 1;
            if (r && sz > 0) begin
                m_ovf = 0;
                void'(q.pop_front());
            end
            if (w && sz < Depth) begin
                m_unf = 0;
                q.push_back(d);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " empty"}, 32'(fifo_empty), 32'(q.size() == 0));
        chk({tag, " full"}, 32'(fifo_full), 32'(q.size() == Depth));
        chk({tag, " thr"}, 32'(fifo_threshold), 32'(q.size() >= Thr));
        chk({tag, " ovf"}, 32'(fifo_overflow), 32'(m_ovf));
        chk({tag, " unf"}, 32'(fifo_underflow), 32'(m_unf));
        if (q.size() > 0) chk({tag, " dout"}, 32'(data_out), 32'(q[0]));
    endtask

    // Inputs change just after the falling edge; outputs are sampled there too.
    task automatic step(input logic r_n, input logic w, input logic r, input logic [7:0] d);
        rst_n   = r_n;
        wr      = w;
        rd      = r;
        data_in = d;
        model_edge(r_n, w, r, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       rst_n, wr, rd;
        logic [7:0] din;
        logic       e_empty, e_full, e_thr, e_ovf, e_unf, chk_dout;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r_n, logic w, logic r, logic [7:0] d, logic em,
                                logic fu, logic th, logic ov, logic un, logic cd,
                                logic [7:0] ed);
        vec_t v;
        v.rst_n = r_n; v.wr = w; v.rd = r; v.din = d;
        v.e_empty = em; v.e_full = fu; v.e_thr = th; v.e_ovf = ov; v.e_unf = un;
        v.chk_dout = cd; v.e_dout = ed;
        return v;
    endfunction

    initial begin
        int wp;
        string tag;

        // Directed table: expected values after each edge.
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));   // reset
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));   // idle
        for (int i = 1; i <= 16; i++)
            vecs.push_back(mk(1, 1, 0, 8'(i), 0, i == 16, i >= 8, 0, 0, 1, 8'h01));
        vecs.push_back(mk(1, 1, 0, 8'h11, 0, 1, 1, Err, 0, 1, 8'h01)); // write while full
        for (int k = 1; k <= 16; k++)
            vecs.push_back(mk(1, 0, 1, 8'h00, k == 16, 0, (16 - k) >= 8, 0, 0, k < 16,
                              8'(k + 1)));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, Err, 0, 8'h00)); // read while empty
        vecs.push_back(mk(1, 1, 0, 8'h55, 0, 0, 0, 0, 0, 1, 8'h55));   // clears underflow
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));   // drain

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].din);
            tag = $sformatf("vec%0d", i);
            chk({tag, " empty"}, 32'(fifo_empty), 32'(vecs[i].e_empty));
            chk({tag, " full"}, 32'(fifo_full), 32'(vecs[i].e_full));
            chk({tag, " thr"}, 32'(fifo_threshold), 32'(vecs[i].e_thr));
            chk({tag, " ovf"}, 32'(fifo_overflow), 32'(vecs[i].e_ovf));
            chk({tag, " unf"}, 32'(fifo_underflow), 32'(vecs[i].e_unf));
            if (vecs[i].chk_dout) chk({tag, " dout"}, 32'(data_out), 32'(vecs[i].e_dout));
        end

        // Occupancy 5 held through many simultaneous read+write cycles so the
        // write pointer wraps past 31 back to 0.
        step(0, 0, 0, 8'h00);
        chk_model("rst2");
        for (int i = 0; i < 5; i++) step(1, 1, 0, 8'(8'hA0 + i));
        chk_model("occ5");
        wp = 5;
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 1, 8'(8'hB0 + i));
            wp = (wp + 1) % 32;
            chk(" simul occ", 32'(q.size()), 32'd5);
            chk_model($sformatf("simul%0d", i));
        end
        chk("wptr wrapped", 32'(wp), 32'd13);
        // Underflow set, then reset mid-stream with requests asserted.
        for (int i = 0; i < 6; i++) step(1, 0, 1, 8'h00);
        chk_model("underflow");
        step(1, 1, 0, 8'h77);
        step(1, 1, 1, 8'h78);
        step(0, 1, 1, 8'h79);
        chk("midrst empty", 32'(fifo_empty), 32'd1);
        chk("midrst ovf", 32'(fifo_overflow), 32'd0);
        chk("midrst unf", 32'(fifo_underflow), 32'd0);
        chk_model("midrst");

        // Randomized traffic with shifting write/read bias and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int pw, pr;
            case ((i / 250) % 3)
                0: begin pw = 75; pr = 30; end
                1: begin pw = 30; pr = 75; end
                default: begin pw = 55; pr = 55; end
            endcase
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 99) < pw),
                 ($urandom_range(0, 99) < pr),
                 8'($urandom));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_mem.md
# fifo_mem

Synchronous single-clock FIFO, 16 entries × 8 bits, with full, empty, half-full threshold and sticky overflow/underflow status flags. It sits between a byte producer and a byte consumer sharing one clock. The head entry is presented combinationally on `data_out`, so the word at the head is valid at the same clock edge that pops it.

## Interface
- `DATA_WIDTH`, 8, word width.
- `ADDR_WIDTH`, 4, log2 of depth (depth = 16).
- `THRESHOLD`, 8, occupancy at or above which `fifo_threshold` asserts.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr`  in  1  write request.
- `rd`  in  1  read request.
- `data_in`  in  8  write data.
- `data_out`  out  8  head-of-FIFO word, combinational read of `mem[rptr]`.
- `fifo_full`  out  1  occupancy == 16.
- `fifo_empty`  out  1  occupancy == 0.
- `fifo_threshold`  out  1  occupancy >= `THRESHOLD`.
- `fifo_overflow`  out  1  sticky: a write was attempted while full.
- `fifo_underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Pointers `wptr` and `rptr` are `ADDR_WIDTH+1` bits; the MSB is the wrap bit. Occupancy = `wptr - rptr` modulo 32.
- Write accept: `wr & ~fifo_full` stores `data_in` at `mem[wptr[3:0]]` and increments `wptr`.
- Read accept: `rd & ~fifo_empty` increments `rptr`. The consumer takes `data_out` before that same edge.
- Simultaneous accepted read and write: both pointers advance and occupancy is unchanged. When the FIFO is full, a read and write in the same cycle accepts the read only. When empty, it accepts the write only. No bypass of write data to `data_out` in the same cycle.
- `fifo_empty` = pointers equal, including the wrap bit.
- `fifo_full` = wrap bits differ and low bits equal.
- `fifo_threshold` = occupancy >= 8.
- `fifo_overflow` is set on any edge with `wr & fifo_full & ~rd`. It is cleared by any accepted read.
- `fifo_underflow` is set on any edge with `rd & fifo_empty & ~wr`. It is cleared by any accepted write.
- Rejected writes leave memory and pointers untouched. Rejected reads leave `rptr` untouched.

## Timing
- Reset (`rst_n` low at a rising edge):
  - `wptr` = `rptr` = 0.
  - `fifo_empty` = 1; `fifo_full`, `fifo_threshold`, `fifo_overflow`, `fifo_underflow` = 0.
  - The storage array is not reset. `data_out` is undefined until the first write.
  - Reset overrides `wr`/`rd` in the same cycle. A mid-operation reset discards all contents.
- Write latency: data written at edge N is visible on `data_out` after edge N if the FIFO was empty. `fifo_empty` deasserts after edge N.
- `fifo_full`, `fifo_empty` and `fifo_threshold` are combinational from the registered pointers and change only after clock edges.
- Overflow and underflow flags are registered and update one edge after the offending request.
- Pointers wrap from 31 to 0 with no special handling.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined: the overflow and underflow sticky registers are implemented as described.
- `FIFO_ERR_FLAGS_EN` undefined: `fifo_overflow` and `fifo_underflow` are tied to 0. Full/empty blocking of writes and reads is unchanged.

## Structure
- Package `fifo_mem_pkg` holds `DATA_WIDTH`, `ADDR_WIDTH`, `DEPTH` (16), `THRESHOLD` and a `ptr_t` typedef of `ADDR_WIDTH+1` bits.
- One sub-module, `fifo_mem_ram`: 16×8 array with one synchronous write port and one asynchronous read port.
- Top-level `fifo_mem` holds the pointers, flag logic and sticky registers.

## Test plan
- Reset then idle: after reset, `fifo_empty`=1 and all other flags are 0.
- Write 0x01..0x10 (16 writes):
  - `fifo_threshold` rises after the 8th write.
  - `fifo_full`=1 after the 16th write.
  - `data_out`=0x01 throughout.
- 17th write of 0x11 while full: write is rejected, `fifo_overflow`=1 on the next edge, contents unchanged.
- 16 reads:
  - `data_out` equals 0x01..0x10 in order at each accepted read.
  - `fifo_overflow` clears on the first read; `fifo_full` clears after it.
  - `fifo_empty`=1 after the 16th read.
- 17th read while empty: `rptr` is unchanged and `fifo_underflow`=1. A subsequent write of 0x55 clears it, and `data_out`=0x55.
- Simultaneous read+write at occupancy 5, then reset asserted mid-stream:
  - Occupancy stays 5 across the simultaneous cycle, and `wptr` wraps 31→0 correctly.
  - After reset, `fifo_empty`=1 and both sticky flags are 0.
